// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM encoding and constants for the UART transmit arbiters
package uart_arb_pkg;
   typedef enum logic [1:0] {IDLE, PREFIX, LOAD, WAIT} arb_state_t;
   localparam logic [7:0] PREFIX_BASE = 8'hF8;
   localparam int NREQ_MAX = 8;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin select, first request after ptr wins (wraps modulo N)
module rr_pick #(
   parameter int N = 2,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);
   logic [IW-1:0] cand;
   // scan ptr+1 .. ptr+N and keep the first requester found
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      cand = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IW'((int'(ptr) + k) % N);
         if (!any && req[cand]) begin
            any = 1'b1;
            gnt[cand] = 1'b1;
            idx = cand;
         end
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART transmitter; UART_TX_ARB_PREFIX_EN adds a channel-prefix byte per grant
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int MAX_BURST = 64
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ack,
   output logic [NREQ-1:0]   grant,
   output logic              busy,
   output logic [7:0]        tx_data,
   output logic              tx_wr,
   input  logic              tx_done
);
   localparam int IW = $clog2(NREQ);
   localparam int BW = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
`ifdef UART_TX_ARB_PREFIX_EN
   localparam arb_state_t FIRST = PREFIX;
`else
   localparam arb_state_t FIRST = LOAD;
`endif
   arb_state_t state, state_nx;
   logic [IW-1:0] rr_ptr, owner, pick_idx;
   logic [NREQ-1:0] pick_gnt;
   logic pick_any;
   logic [BW-1:0] burst_cnt;
   logic last_q, is_prefix, rel;
   logic [7:0] bytes [NREQ];
   for (genvar i = 0; i < NREQ; i++) begin : g_slice
      assign bytes[i] = req_data[8*i +: 8];
   end
   rr_pick #(.N(NREQ)) u_pick (
      .req (req_valid),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );
   assign rel = last_q || (MAX_BURST != 0 && burst_cnt == BW'(MAX_BURST));
   assign busy = state != IDLE;
   // state register
   always_ff @(posedge sys_clk) state <= sys_rst ? IDLE : state_nx;
   // next-state: a write is only issued from LOAD/PREFIX, so WAIT guards the single outstanding byte
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (pick_any) state_nx = FIRST;
`ifdef UART_TX_ARB_PREFIX_EN
         PREFIX:  state_nx = WAIT;
`endif
         LOAD:    if (req_valid[owner]) state_nx = WAIT;
         WAIT:    if (tx_done) state_nx = (!is_prefix && rel) ? IDLE : LOAD;
         default: state_nx = IDLE;
      endcase
   end
   // registered outputs and datapath; strobes default low so they pulse for one cycle
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         tx_data   <= '0;
         tx_wr     <= 1'b0;
         req_ack   <= '0;
         grant     <= '0;
         rr_ptr    <= IW'(NREQ - 1);
         owner     <= '0;
         burst_cnt <= '0;
         last_q    <= 1'b0;
         is_prefix <= 1'b0;
      end else begin
         tx_wr   <= 1'b0;
         req_ack <= '0;
         case (state)
            IDLE: if (pick_any) begin
               grant     <= pick_gnt;
               owner     <= pick_idx;
               burst_cnt <= '0;
            end
`ifdef UART_TX_ARB_PREFIX_EN
            PREFIX: begin
               tx_data   <= PREFIX_BASE | 8'(owner);
               tx_wr     <= 1'b1;
               is_prefix <= 1'b1;
            end
`endif
            LOAD: if (req_valid[owner]) begin
               tx_data        <= bytes[owner];
               tx_wr          <= 1'b1;
               req_ack[owner] <= 1'b1;
               last_q         <= req_last[owner];
               is_prefix      <= 1'b0;
               if (MAX_BURST != 0) burst_cnt <= burst_cnt + 1'b1;
            end
            WAIT: if (tx_done && !is_prefix && rel) begin
               grant  <= '0;
               rr_ptr <= owner;
            end
            default: ;
         endcase
      end
   end
endmodule
